// File: rtl/child_result_gather_pkg.sv
// Shared types and constants for the child result gatherer and its rr_pick arbiter.
package child_gather_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    OFFER = 2'd2,
    DONE  = 2'd3
  } gather_state_e;

  localparam int NUM_CHILDREN_DEF = 6;
  localparam int DATA_W_DEF       = 32;

  // Width of a child index; a single child still needs one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/child_result_gather_if.sv
// Result stream from the gatherer (master) to the parent core (slave).
interface child_result_gather_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3
);
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_val_1;
  logic [DATA_W-1:0] out_val_2;

  modport master (output out_valid, output out_idx, output out_val_1, output out_val_2,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_idx, input  out_val_1, input  out_val_2,
                  output out_ready);
endinterface

// File: rtl/child_result_gather_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping at N-1.
module rr_pick #(
  parameter int N     = 6,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest hit is the last assignment.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/child_result_gather.sv
// Gathers (val_1, val_2) results from NUM_CHILDREN children into one handshaked stream.
// Optional running minimum on val_1 when CHILD_GATHER_MIN_REDUCE_EN is defined.
module child_result_gather
  import child_gather_pkg::*;
#(
  parameter int NUM_CHILDREN = NUM_CHILDREN_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int IDX_W        = idx_w(NUM_CHILDREN)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_CHILDREN-1:0]        child_flag,
  input  logic [NUM_CHILDREN*DATA_W-1:0] child_val_1,
  input  logic [NUM_CHILDREN*DATA_W-1:0] child_val_2,
  child_result_gather_if.master          out_if,
  output logic [NUM_CHILDREN-1:0]        collected,
  output logic                           busy,
  output logic                           all_done
`ifdef CHILD_GATHER_MIN_REDUCE_EN
  ,
  output logic [DATA_W-1:0]              min_val_1,
  output logic [DATA_W-1:0]              min_val_2,
  output logic [IDX_W-1:0]               min_idx
`endif
);

  gather_state_e state;
  logic [IDX_W-1:0]  rr_ptr;
  logic              out_valid_q;
  logic [IDX_W-1:0]  out_idx_q;
  logic [DATA_W-1:0] out_val_1_q, out_val_2_q;
  logic [NUM_CHILDREN-1:0] collected_q;
  logic              busy_q, all_done_q;

  logic [NUM_CHILDREN-1:0][DATA_W-1:0] val_1_arr, val_2_arr;
  logic [NUM_CHILDREN-1:0] cand, acc_mask, coll_next;
  logic [IDX_W-1:0]  ptr_next, pick_idx;
  logic              pick_found;

  assign val_1_arr = child_val_1;
  assign val_2_arr = child_val_2;

  // Already-accepted children are masked out even if their flag stays high.
  assign cand      = child_flag & ~collected_q;
  assign acc_mask  = NUM_CHILDREN'(1) << out_idx_q;
  assign coll_next = collected_q | acc_mask;
  assign ptr_next  = (out_idx_q == IDX_W'(NUM_CHILDREN - 1)) ? '0 : IDX_W'(out_idx_q + 1'b1);

  rr_pick #(.N(NUM_CHILDREN), .IDX_W(IDX_W)) u_pick (
    .req   (cand),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef CHILD_GATHER_MIN_REDUCE_EN
  logic [DATA_W-1:0] min_val_1_q, min_val_2_q;
  logic [IDX_W-1:0]  min_idx_q;
  logic              take_min;
  // Empty collected set at handshake means this is the first result since start.
  assign take_min  = (collected_q == '0) || (out_val_1_q < min_val_1_q);
  assign min_val_1 = min_val_1_q;
  assign min_val_2 = min_val_2_q;
  assign min_idx   = min_idx_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_val_1_q <= '0;
      out_val_2_q <= '0;
      collected_q <= '0;
      busy_q      <= 1'b0;
      all_done_q  <= 1'b0;
`ifdef CHILD_GATHER_MIN_REDUCE_EN
      min_val_1_q <= '1;
      min_val_2_q <= '1;
      min_idx_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= SCAN;
            collected_q <= '0;
            all_done_q  <= 1'b0;
            busy_q      <= 1'b1;
`ifdef CHILD_GATHER_MIN_REDUCE_EN
            min_val_1_q <= '1;
            min_val_2_q <= '1;
            min_idx_q   <= '0;
`endif
          end
        end
        SCAN: begin
          if (pick_found) begin
            state       <= OFFER;
            out_valid_q <= 1'b1;
            out_idx_q   <= pick_idx;
            out_val_1_q <= val_1_arr[pick_idx];
            out_val_2_q <= val_2_arr[pick_idx];
          end
        end
        OFFER: begin
          // Captured result stays frozen until the parent takes it.
          if (out_if.out_ready) begin
            collected_q <= coll_next;
            rr_ptr      <= ptr_next;
            out_valid_q <= 1'b0;
`ifdef CHILD_GATHER_MIN_REDUCE_EN
            if (take_min) begin
              min_val_1_q <= out_val_1_q;
              min_val_2_q <= out_val_2_q;
              min_idx_q   <= out_idx_q;
            end
`endif
            if (&coll_next) begin
              state      <= DONE;
              busy_q     <= 1'b0;
              all_done_q <= 1'b1;
            end else begin
              state <= SCAN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_idx   = out_idx_q;
  assign out_if.out_val_1 = out_val_1_q;
  assign out_if.out_val_2 = out_val_2_q;
  assign collected        = collected_q;
  assign busy             = busy_q;
  assign all_done         = all_done_q;

endmodule

// File: tb/tb_child_result_gather.sv
// Bench for child_result_gather: directed scenarios plus random traffic vs a transaction-level model.
module tb_child_result_gather;
  localparam int N  = 6;
  localparam int DW = 32;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [N-1:0] flags;
  logic [N-1:0][DW-1:0] tb_v1, tb_v2;
  logic [N-1:0] collected;
  logic busy, all_done;
`ifdef CHILD_GATHER_MIN_REDUCE_EN
  logic [DW-1:0] min_val_1, min_val_2;
  logic [IW-1:0] min_idx;
`endif

  child_result_gather_if #(.DATA_W(DW), .IDX_W(IW)) out_if ();

  child_result_gather #(.NUM_CHILDREN(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .child_flag  (flags),
    .child_val_1 (tb_v1),
    .child_val_2 (tb_v2),
    .out_if      (out_if),
    .collected   (collected),
    .busy        (busy),
    .all_done    (all_done)
`ifdef CHILD_GATHER_MIN_REDUCE_EN
    ,
    .min_val_1   (min_val_1),
    .min_val_2   (min_val_2),
    .min_idx     (min_idx)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference model: what the parent should see, tracked as sets and a pointer.
  bit          m_valid, m_busy, m_done;
  int          m_idx, m_ptr;
  logic [DW-1:0] m_v1, m_v2;
  bit [N-1:0]  m_coll;
  int          acc_idx_q[$];
  logic [DW-1:0] acc_v1_q[$], acc_v2_q[$];
  int          seen_q[$];

  function automatic int pick(input bit [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_busy = 0; m_done = 0; m_idx = 0; m_ptr = 0;
    m_v1 = '0; m_v2 = '0; m_coll = '0;
    acc_idx_q.delete(); acc_v1_q.delete(); acc_v2_q.delete();
  endtask

  task automatic model_clk();
    int p;
    if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_done = 0; m_coll = '0;
        acc_idx_q.delete(); acc_v1_q.delete(); acc_v2_q.delete();
      end
    end else if (!m_valid) begin
      p = pick(flags & ~m_coll, m_ptr);
      if (p >= 0) begin
        m_valid = 1; m_idx = p; m_v1 = tb_v1[p]; m_v2 = tb_v2[p];
      end
    end else if (out_if.out_ready) begin
      m_coll[m_idx] = 1'b1;
      m_ptr = (m_idx + 1) % N;
      m_valid = 0;
      acc_idx_q.push_back(m_idx); acc_v1_q.push_back(m_v1); acc_v2_q.push_back(m_v2);
      if (&m_coll) begin m_busy = 0; m_done = 1; end
    end
  endtask

  task automatic check_outputs();
    chk("valid", out_if.out_valid, m_valid);
    if (m_valid) begin
      chk("out_idx", out_if.out_idx, m_idx);
      chk("out_val_1", out_if.out_val_1, m_v1);
      chk("out_val_2", out_if.out_val_2, m_v2);
    end
    chk("collected", collected, m_coll);
    chk("busy", busy, m_busy);
    chk("all_done", all_done, m_done);
`ifdef CHILD_GATHER_MIN_REDUCE_EN
    if (acc_idx_q.size() == 0) begin
      chk("min_v1_clr", min_val_1, {DW{1'b1}});
      chk("min_idx_clr", min_idx, 0);
    end else if (m_done) begin
      int b = 0;
      for (int i = 1; i < acc_idx_q.size(); i++)
        if (acc_v1_q[i] < acc_v1_q[b]) b = i;
      chk("min_val_1", min_val_1, acc_v1_q[b]);
      chk("min_val_2", min_val_2, acc_v2_q[b]);
      chk("min_idx", min_idx, acc_idx_q[b]);
    end
`endif
  endtask

  // Called just after a falling edge with inputs already set for the next rising edge.
  task automatic step();
    check_outputs();
    if (out_if.out_valid && out_if.out_ready) seen_q.push_back(int'(out_if.out_idx));
    model_clk();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b1; start = 0; flags = '0; tb_v1 = '0; tb_v2 = '0; out_if.out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_valid", out_if.out_valid, 0);
    chk("rst_idx", out_if.out_idx, 0);
    chk("rst_v1", out_if.out_val_1, 0);
    chk("rst_v2", out_if.out_val_2, 0);
    chk("rst_coll", collected, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", all_done, 0);

    // Single child, one-cycle flag-to-valid
    start = 1; out_if.out_ready = 1; step(); start = 0;
    flags = 6'b000100; tb_v1[2] = 32'h10; tb_v2[2] = 32'h20;
    step();
    chk("single_valid", out_if.out_valid, 1);
    chk("single_idx", out_if.out_idx, 2);
    chk("single_v1", out_if.out_val_1, 32'h10);
    chk("single_v2", out_if.out_val_2, 32'h20);
    step();
    chk("single_coll", collected, 6'b000100);

    // Asynchronous reset while child 2 is being offered
    do_reset();
    start = 1; out_if.out_ready = 0; flags = 6'b000100; step(); start = 0;
    step();
    chk("rstoff_pre_valid", out_if.out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rstoff_valid", out_if.out_valid, 0);
    chk("rstoff_coll", collected, 0);
    chk("rstoff_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    out_if.out_ready = 1;
    repeat (4) step();
    chk("rstoff_idle", out_if.out_valid, 0);

    // All flags together from rr_ptr 0: order 0..5, done after 12 cycles
    tb_v1[0] = 7; tb_v1[1] = 3; tb_v1[2] = 9; tb_v1[3] = 3; tb_v1[4] = 5; tb_v1[5] = 8;
    for (int i = 0; i < N; i++) tb_v2[i] = 32'hA0 + i;
    flags = '1; start = 1; step(); start = 0;
    seen_q.delete();
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 11) chk("all_done_early", all_done, 0);
    end
    chk("all_done_12", all_done, 1);
    chk("all_order_n", seen_q.size(), N);
    for (int i = 0; i < seen_q.size(); i++) chk("all_order", seen_q[i], i);
`ifdef CHILD_GATHER_MIN_REDUCE_EN
    chk("min_tie_v1", min_val_1, 3);
    chk("min_tie_idx", min_idx, 1);
`endif

    // Backpressure on child 4 while its inputs change
    flags = 6'b010000; out_if.out_ready = 0; tb_v1[4] = 32'h44;
    start = 1; step(); start = 0;
    step();
    for (int c = 0; c < 5; c++) begin
      tb_v1[4] = 32'hFF;
      flags = (c[0]) ? 6'b000000 : 6'b010000;
      step();
      chk("bp_hold_v1", out_if.out_val_1, 32'h44);
      chk("bp_hold_valid", out_if.out_valid, 1);
    end
    out_if.out_ready = 1; flags = 6'b010000;
    seen_q.delete();
    repeat (4) step();
    chk("bp_once", seen_q.size(), 1);
    chk("bp_coll", collected, 6'b010000);

    // Held flag not re-picked; last accept of child 0 leaves rr_ptr at 1
    flags = 6'b000010;
    step(); step();
    repeat (3) begin
      step();
      chk("held_no_reoffer", out_if.out_valid, 0);
    end
    flags = '1;
    guard = 0;
    while (!all_done && guard < 20) begin step(); guard++; end
    chk("held_done", all_done, 1);
    start = 1; step(); start = 0;
    step();
    chk("restart_valid", out_if.out_valid, 1);
    chk("restart_idx", out_if.out_idx, 1);

    // Random traffic, including start pulses mid-gather that must be ignored
    for (int c = 0; c < 1500; c++) begin
      start = ($urandom_range(0, 19) == 0);
      out_if.out_ready = $urandom_range(0, 1);
      for (int i = 0; i < N; i++) begin
        flags[i] = ($urandom_range(0, 9) < 4);
        tb_v1[i] = $urandom_range(0, 15);
        tb_v2[i] = $urandom;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
